// File: rtl/sketch_pkg.sv
// Shared constants and FSM encoding for the sketch drawing sequencer.
package sketch_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sketch_xy_scan.sv
// Raster scan counter: cx runs fastest over 0..x_lim-1, cy over 0..y_lim-1.
module sketch_xy_scan
    import sketch_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [X_W-1:0]   x_lim,
    input  logic [Y_W-1:0]   y_lim,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic             last
);

    logic x_end;
    logic y_end;

    assign x_end = (cx == x_lim - X_W'(1));
    assign y_end = (cy == y_lim - Y_W'(1));
    assign last  = x_end && y_end;

    always_ff @(posedge clock) begin
        if (!resetn || clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (x_end) begin
                cx <= '0;
                cy <= y_end ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sketch_draw_ctrl.sv
// Draws a SIZE x SIZE square or clears the frame, one registered pixel write per cycle.
module sketch_draw_ctrl #(
    parameter int SIZE     = 4,
    parameter int SCREEN_W = sketch_pkg::SCREEN_W,
    parameter int SCREEN_H = sketch_pkg::SCREEN_H
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         clear,
    input  logic [sketch_pkg::X_W-1:0]   x_in,
    input  logic [sketch_pkg::Y_W-1:0]   y_in,
    input  logic [sketch_pkg::COL_W-1:0] colour_in,
    output logic                         busy,
    output logic                         done,
    output logic [sketch_pkg::X_W-1:0]   vga_x,
    output logic [sketch_pkg::Y_W-1:0]   vga_y,
    output logic [sketch_pkg::COL_W-1:0] vga_colour,
    output logic                         vga_plot
);
    import sketch_pkg::*;

    localparam logic [X_W-1:0] SQ_X   = X_W'(SIZE);
    localparam logic [Y_W-1:0] SQ_Y   = Y_W'(SIZE);
    localparam logic [X_W-1:0] FULL_X = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] FULL_Y = Y_W'(SCREEN_H);
    localparam logic [X_W:0]   CLIP_X = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   CLIP_Y = (Y_W+1)'(SCREEN_H);

    state_t             state;
    state_t             state_next;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [COL_W-1:0]   col0;
    logic               scan_clr;
    logic               scan_en;
    logic               scan_last;
    logic [X_W-1:0]     x_lim;
    logic [Y_W-1:0]     y_lim;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic               accept_draw;

    assign scan_clr    = (state == IDLE);
    assign scan_en     = (state == DRAW) || (state == CLEAR);
    assign x_lim       = (state == CLEAR) ? FULL_X : SQ_X;
    assign y_lim       = (state == CLEAR) ? FULL_Y : SQ_Y;
    assign accept_draw = (state == IDLE) && !clear && start;

    // One extra bit on each sum so off-screen pixels are detected instead of wrapping.
    assign sum_x = {1'b0, x0} + {1'b0, cx};
    assign sum_y = {1'b0, y0} + {1'b0, cy};

    sketch_xy_scan u_scan (
        .clock  (clock),
        .resetn (resetn),
        .clr    (scan_clr),
        .en     (scan_en),
        .x_lim  (x_lim),
        .y_lim  (y_lim),
        .cx     (cx),
        .cy     (cy),
        .last   (scan_last)
    );

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear)      state_next = CLEAR;
                else if (start) state_next = DRAW;
            end
            DRAW:    if (scan_last) state_next = DONE;
            CLEAR:   if (scan_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x0   <= '0;
            y0   <= '0;
            col0 <= '0;
        end else if (accept_draw) begin
            x0   <= x_in;
            y0   <= y_in;
            col0 <= colour_in;
        end
    end

    // Clipped pixels still take their scan cycle so run length never varies.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            busy     <= scan_en;
            done     <= (state == DONE);
            vga_plot <= 1'b0;
            case (state)
                DRAW: begin
                    vga_x      <= sum_x[X_W-1:0];
                    vga_y      <= sum_y[Y_W-1:0];
                    vga_colour <= col0;
                    vga_plot   <= (sum_x < CLIP_X) && (sum_y < CLIP_Y);
                end
                CLEAR: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= '0;
                    vga_plot   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sketch_draw_ctrl.sv
// Randomised scoreboard bench for sketch_draw_ctrl against a pixel-list reference model.
module tb_sketch_draw_ctrl;

    localparam int SIZE = 4;
    localparam int SW   = 160;
    localparam int SH   = 120;

    typedef struct {
        bit is_done;
        int cyc;
        int x;
        int y;
        int col;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       clear;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   next_ok    = 0;
    int   n_checks   = 0;
    int   n_fails    = 0;
    int   n_accepted = 0;
    bit   last_was_clear;
    int   accept_edge;

    sketch_draw_ctrl #(.SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .clear      (clear),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic checkOutput(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: list every on-screen pixel of the request in raster order with its visible cycle.
    task automatic modelAccept(input bit is_clear, input int xs, input int ys, input int col, input int e);
        int w;
        int h;
        int px;
        int py;
        exp_t t;
        w = is_clear ? SW : SIZE;
        h = is_clear ? SH : SIZE;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                px = is_clear ? i : xs + i;
                py = is_clear ? j : ys + j;
                if (px < SW && py < SH) begin
                    t = '{is_done: 1'b0, cyc: e + 1 + j * w + i, x: px, y: py, col: is_clear ? 0 : col};
                    exp_q.push_back(t);
                end
            end
        end
        t = '{is_done: 1'b1, cyc: e + w * h + 1, x: 0, y: 0, col: 0};
        exp_q.push_back(t);
        next_ok        = e + w * h + 2;
        last_was_clear = is_clear;
        accept_edge    = e;
        n_accepted++;
    endtask

    task automatic applyStimulus(input bit rn, input bit st, input bit cl, input int x, input int y, input int c);
        resetn    = rn;
        start     = st;
        clear     = cl;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(c);
        @(posedge clock);
        #1;
        if (!resetn) begin
            exp_q.delete();
            next_ok = cyc + 1;
        end else if (cyc >= next_ok && (clear || start)) begin
            modelAccept(clear, int'(x_in), int'(y_in), int'(colour_in), cyc);
        end
    endtask

    task automatic idleTick();
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom % 256, $urandom % 128, $urandom % 8);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (next_ok > cyc + 1 && guard < 25000) begin
            idleTick();
            guard++;
        end
        checkOutput("wait_idle_timeout", int'(next_ok > cyc + 1), 0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (vga_plot === 1'b1 || done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("[TB] FAIL unexpected_output: plot=%0d done=%0d x=%0d y=%0d at cycle %0d, expected no activity",
                         vga_plot, done, vga_x, vga_y, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done) begin
                    if (!(done === 1'b1 && vga_plot === 1'b0 && cyc == e.cyc)) begin
                        n_fails++;
                        $display("[TB] FAIL done_pulse: got done=%0d plot=%0d at cycle %0d, expected done=1 plot=0 at cycle %0d",
                                 done, vga_plot, cyc, e.cyc);
                    end
                    checkOutput("busy_in_done", int'(busy), 0);
                end else begin
                    if (!(vga_plot === 1'b1 && done === 1'b0 && int'(vga_x) == e.x && int'(vga_y) == e.y &&
                          int'(vga_colour) == e.col && cyc == e.cyc)) begin
                        n_fails++;
                        $display("[TB] FAIL pixel: got plot=%0d done=%0d (%0d,%0d) col=%0d cycle %0d, expected plot (%0d,%0d) col=%0d cycle %0d",
                                 vga_plot, done, vga_x, vga_y, vga_colour, cyc, e.x, e.y, e.col, e.cyc);
                    end
                    checkOutput("busy_while_plot", int'(busy), 1);
                end
            end
        end
    end

    initial begin
        int guard;
        resetn = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        x_in = '0;
        y_in = '0;
        colour_in = '0;

        // Reset held with start high: outputs stay zero, nothing accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 10, 20, 4);
            checkOutput("rst_busy", int'(busy), 0);
            checkOutput("rst_done", int'(done), 0);
            checkOutput("rst_plot", int'(vga_plot), 0);
            checkOutput("rst_x", int'(vga_x), 0);
            checkOutput("rst_y", int'(vga_y), 0);
            checkOutput("rst_colour", int'(vga_colour), 0);
        end

        $display("[TB] directed draw at (10,20)");
        applyStimulus(1'b1, 1'b1, 1'b0, 10, 20, 4);
        waitIdle();

        $display("[TB] clipped draw at (158,118)");
        applyStimulus(1'b1, 1'b1, 1'b0, 158, 118, 5);
        waitIdle();

        $display("[TB] clear and start together, start held");
        applyStimulus(1'b1, 1'b1, 1'b1, 7, 9, 2);
        checkOutput("clear_wins", int'(last_was_clear), 1);
        guard = 0;
        while (last_was_clear && guard < 25000) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 7, 9, 2);
            guard++;
        end
        checkOutput("held_start_redraw", int'(last_was_clear), 0);
        waitIdle();

        $display("[TB] random requests with pulses while busy");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, ($urandom % 4) == 0, 1'b0, $urandom % 256, $urandom % 128, $urandom % 8);
        end
        waitIdle();

        $display("[TB] reset after the fifth plot");
        applyStimulus(1'b1, 1'b1, 1'b0, 40, 50, 6);
        for (int i = 0; i < 5; i++) idleTick();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        checkOutput("midrst_plot", int'(vga_plot), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 3);
        waitIdle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 25000) begin
            idleTick();
            guard++;
        end
        idleTick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
